uart_rx_cfg: RTL and testbench

//  Configurable UART receiver that replaces the fixed 8/N/1 receiver on the debug-bus serial link.

---
 rtl/uart_rx_cfg.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: sync, false-start reject, parity/frame/break flags.
// Define UART_RX_MAJORITY_EN for a 2-of-3 vote around each bit mid-point.
module uart_rx_cfg #(
    parameter int CLK_FREQ    = 250000,
    parameter int BAUD        = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_in,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break,
    output logic                 o_busy
);

    localparam int CPB = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(CPB) + 1;
    localparam int IW  = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
    localparam int MOFS = 1;
`else
    localparam int MOFS = 0;
`endif
    localparam logic [CW-1:0] HALF_LD   = CW'(CPB / 2 - 1 + MOFS);
    localparam logic [CW-1:0] BIT_LD    = CW'(CPB - 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PAR, STOP, WAIT_HIGH
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   rxs;
    logic                   armed;
    logic                   bit_s;
    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic [DATA_BITS-1:0]   sh;
    logic                   par;
    logic                   perr;
    logic                   ferr;
    logic                   zero;
    logic                   tick;

    assign rxs  = sync[SYNC_STAGES-1];
    assign tick = (cnt == '0);

    // armed only once a real high has reached rxs, so a low line at reset exit is ignored
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync  <= '1;
            fill  <= '0;
            armed <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], i_in};
            fill  <= {fill[SYNC_STAGES-2:0], 1'b1};
            armed <= armed | (fill[SYNC_STAGES-1] & rxs);
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) hist <= '1;
        else          hist <= {hist[0], rxs};
    end

    assign bit_s = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);
`else
    assign bit_s = rxs;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            sh           <= '0;
            par          <= 1'b0;
            perr         <= 1'b0;
            ferr         <= 1'b0;
            zero         <= 1'b0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
            if (state != IDLE && !tick) cnt <= cnt - 1'b1;
            unique case (state)
                IDLE: begin
                    if (armed && !rxs) begin
                        state  <= START;
                        cnt    <= HALF_LD;
                        o_busy <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (bit_s) begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end else begin
                            state <= DATA;
                            cnt   <= BIT_LD;
                            idx   <= '0;
                            par   <= 1'b0;
                            perr  <= 1'b0;
                            ferr  <= 1'b0;
                            zero  <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        sh   <= {bit_s, sh[DATA_BITS-1:1]};
                        par  <= par ^ bit_s;
                        zero <= zero & ~bit_s;
                        cnt  <= BIT_LD;
                        if (idx == LAST_DATA) begin
                            idx   <= '0;
                            state <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                PAR: begin
                    if (tick) begin
                        perr  <= (PARITY == 1) ? ~(par ^ bit_s) : (par ^ bit_s);
                        zero  <= zero & ~bit_s;
                        cnt   <= BIT_LD;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        cnt <= BIT_LD;
                        if (idx == LAST_STOP) begin
                            o_data       <= sh;
                            o_valid      <= 1'b1;
                            o_parity_err <= perr;
                            o_frame_err  <= ferr | ~bit_s;
                            o_break      <= zero & ((idx != '0) | ~bit_s);
                            if (bit_s) begin
                                state  <= IDLE;
                                o_busy <= 1'b0;
                            end else begin
                                state <= WAIT_HIGH;
                            end
                        end else begin
                            ferr <= ferr | ~bit_s;
                            zero <= zero & ((idx != '0) | ~bit_s);
                            idx  <= idx + 1'b1;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rxs) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three receivers (8N1, 8E1, 8N2) at 16 clk/bit.
// Expected frames are queued as they are sent and popped on each o_valid.
module tb_uart_rx_cfg;

    localparam int CPB = 16;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] ln = '1;

    logic [7:0] d_a, d_b, d_c;
    logic       v_a, v_b, v_c;
    logic       pe_a, pe_b, pe_c;
    logic       fe_a, fe_b, fe_c;
    logic       bk_a, bk_b, bk_c;
    logic       by_a, by_b, by_c;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_rx_cfg #(
        .CLK_FREQ(160000), .BAUD(10000), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)
    ) u_n1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in(ln[0]),
        .o_data(d_a), .o_valid(v_a), .o_parity_err(pe_a),
        .o_frame_err(fe_a), .o_break(bk_a), .o_busy(by_a)
    );

    uart_rx_cfg #(
        .CLK_FREQ(160000), .BAUD(10000), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)
    ) u_e1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in(ln[1]),
        .o_data(d_b), .o_valid(v_b), .o_parity_err(pe_b),
        .o_frame_err(fe_b), .o_break(bk_b), .o_busy(by_b)
    );

    uart_rx_cfg #(
        .CLK_FREQ(160000), .BAUD(10000), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(2), .SYNC_STAGES(2)
    ) u_n2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in(ln[2]),
        .o_data(d_c), .o_valid(v_c), .o_parity_err(pe_c),
        .o_frame_err(fe_c), .o_break(bk_c), .o_busy(by_c)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int s, input logic [7:0] d,
                        input logic pe, input logic fe, input logic bk);
        exp_t e;
        e = '{d: d, pe: pe, fe: fe, bk: bk};
        if (s == 0)      qa.push_back(e);
        else if (s == 1) qb.push_back(e);
        else             qc.push_back(e);
    endtask

    task automatic mon(input int s, input logic [7:0] d, input logic [2:0] f);
        exp_t e;
        int   sz;
        e  = '0;
        sz = (s == 0) ? qa.size() : (s == 1) ? qb.size() : qc.size();
        chk($sformatf("s%0d_pending", s), 32'(sz != 0), 32'd1);
        if (sz != 0) begin
            if (s == 0)      e = qa.pop_front();
            else if (s == 1) e = qb.pop_front();
            else             e = qc.pop_front();
            chk($sformatf("s%0d_data", s), 32'(d), 32'(e.d));
            chk($sformatf("s%0d_flags", s), 32'(f), 32'({e.pe, e.fe, e.bk}));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (v_a) mon(0, d_a, {pe_a, fe_a, bk_a});
            if (v_b) mon(1, d_b, {pe_b, fe_b, bk_b});
            if (v_c) mon(2, d_c, {pe_c, fe_c, bk_c});
        end
    end

    task automatic put_bit(input int s, input logic b, input logic flip);
        ln[s] = b;
        if (flip) begin
            repeat (CPB / 2) @(negedge clk);
            ln[s] = ~b;
            @(negedge clk);
            ln[s] = b;
            repeat (CPB / 2 - 1) @(negedge clk);
        end else begin
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send(input int s, input logic [7:0] d, input logic has_par,
                        input logic pb, input int nstop, input logic [1:0] stops,
                        input int flip_at);
        put_bit(s, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) put_bit(s, d[i], i == flip_at);
        if (has_par) put_bit(s, pb, 1'b0);
        for (int i = 0; i < nstop; i++) put_bit(s, stops[i], 1'b0);
        ln[s] = 1'b1;
    endtask

    function automatic logic even_err(input logic [7:0] d, input logic pb);
        return (^d) ^ pb;
    endfunction

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((qa.size() + qb.size() + qc.size()) != 0 && t < 40 * CPB) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(qa.size() + qb.size() + qc.size()), 32'd0);
        repeat (CPB) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int         bc;
        logic [7:0] d;
        logic       pb;

        repeat (3) @(negedge clk);
        chk("reset_a", 32'({d_a, v_a, pe_a, fe_a, bk_a, by_a}), 32'd0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        push(0, 8'hA5, 1'b0, 1'b0, 1'b0);
        push(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        send(0, 8'hA5, 1'b0, 1'b0, 1, 2'b01, -1);
        send(0, 8'h3C, 1'b0, 1'b0, 1, 2'b01, -1);
        drain("t1_drain");

        d = 8'h07;
        for (int k = 0; k < 2; k++) begin
            pb = (k == 0);
            push(1, d, even_err(d, pb), 1'b0, 1'b0);
            send(1, d, 1'b1, pb, 1, 2'b01, -1);
            repeat (2 * CPB) @(negedge clk);
        end
        drain("t2_drain");

        push(2, 8'h33, 1'b0, 1'b1, 1'b0);
        send(2, 8'h33, 1'b0, 1'b0, 2, 2'b01, -1);
        chk("t3_wait_high", 32'(by_c), 32'd1);
        repeat (4) @(negedge clk);
        chk("t3_idle", 32'(by_c), 32'd0);
        push(2, 8'h55, 1'b0, 1'b0, 1'b0);
        send(2, 8'h55, 1'b0, 1'b0, 2, 2'b11, -1);
        drain("t3_drain");

        push(0, 8'h00, 1'b0, 1'b1, 1'b1);
        ln[0] = 1'b0;
        repeat (30 * CPB) @(negedge clk);
        chk("t4_busy_low", 32'(by_a), 32'd1);
        ln[0] = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("t4_idle", 32'(by_a), 32'd0);
        drain("t4_drain");

        ln[0] = 1'b0;
        repeat (3) @(negedge clk);
        ln[0] = 1'b1;
        bc = 0;
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge clk);
            if (by_a) bc++;
        end
        chk("t5_busy_seen", 32'(bc != 0), 32'd1);
        chk("t5_busy_max", 32'(bc <= CPB / 2 + 1), 32'd1);
        drain("t5_drain");

        put_bit(1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) put_bit(1, 1'b1, 1'b0);
        chk("t6_busy_pre", 32'(by_b), 32'd1);
        rst_n = 1'b0;
        ln[1] = 1'b1;
        #1;
        chk("t6_reset_b", 32'({d_b, v_b, pe_b, fe_b, bk_b, by_b}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("t6_idle", 32'({v_b, by_b}), 32'd0);
        d  = 8'h81;
        pb = ^d;
        push(1, d, even_err(d, pb), 1'b0, 1'b0);
        send(1, d, 1'b1, pb, 1, 2'b01, -1);
        drain("t6_drain");

`ifdef UART_RX_MAJORITY_EN
        push(0, 8'hA5, 1'b0, 1'b0, 1'b0);
        send(0, 8'hA5, 1'b0, 1'b0, 1, 2'b01, 3);
        push(0, 8'h5A, 1'b0, 1'b0, 1'b0);
        send(0, 8'h5A, 1'b0, 1'b0, 1, 2'b01, 6);
        drain("t7_drain");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
